// File: rtl/ex_pkg.sv
// Shared types and constants for the multi-cycle execution unit.
package ex_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpLsl = 4'd5,
        OpLsr = 4'd6,
        OpAsr = 4'd7,
        OpMul = 4'd8
    } op_e;

    // Bit positions within the 4-bit flags vector {Z,N,C,V}.
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W iterations,
// returns the low DATA_W bits of the unsigned product.
module ex_mul_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] LAST_ITER = SH_W'(DATA_W - 1);

    logic              r_busy;
    logic [SH_W-1:0]   r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
    // done is high during the final iteration so the caller can latch result on that edge.
    assign done       = r_busy && (r_cnt == LAST_ITER);
    assign result     = w_acc_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc  <= w_acc_next;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_unit_mc.sv
// Execution unit: single-cycle ALU/shifter plus an iterative multiplier, with
// registered result, one-cycle result strobe and optional flag update.
module ex_unit_mc
    import ex_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] immed,
    input  logic              immed_sel,
    input  logic [SH_W-1:0]   shamt_imm,
    input  logic              flag_wen,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        flags,
    output logic              busy
);

    localparam int unsigned MSB = DATA_W - 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_data_out;
    logic [3:0]        r_flags;
    logic              r_mul_fwen;

    op_e               w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_flag_upd;
    logic [3:0]        w_alu_flags;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_res;

    assign w_op        = op_e'(op);
    assign w_a         = immed_sel ? immed : src_a;
    assign w_b         = src_b;
    assign w_shamt     = immed_sel ? shamt_imm : src_a[SH_W-1:0];
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (w_op == OpMul);

    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + (DATA_W + 1)'(1);
    // One guard bit each side so the last bit shifted out lands at a fixed index.
    assign w_lsl = {1'b0, w_b} << w_shamt;
    assign w_lsr = {w_b, 1'b0} >> w_shamt;
    assign w_asr = $signed({w_b, 1'b0}) >>> w_shamt;

    always_comb begin
        w_res      = '0;
        w_c        = r_flags[FLAG_C];
        w_v        = r_flags[FLAG_V];
        w_flag_upd = 1'b1;
        case (w_op)
            OpAdd: begin
                {w_c, w_res} = w_add;
                w_v = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
            end
            OpSub: begin
                {w_c, w_res} = w_sub;
                w_v = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
            end
            OpAnd: w_res = w_a & w_b;
            OpOr:  w_res = w_a | w_b;
            OpXor: w_res = w_a ^ w_b;
            OpLsl: begin
                w_res = w_lsl[DATA_W-1:0];
                if (w_shamt != '0) w_c = w_lsl[DATA_W];
            end
            OpLsr: begin
                w_res = w_lsr[DATA_W:1];
                if (w_shamt != '0) w_c = w_lsr[0];
            end
            OpAsr: begin
                w_res = w_asr[DATA_W:1];
                if (w_shamt != '0) w_c = w_asr[0];
            end
            default: w_flag_upd = 1'b0;
        endcase
        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = (w_res == '0);
        w_alu_flags[FLAG_N] = w_res[MSB];
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_V] = w_v;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_next = MUL;
            MUL:     if (w_mul_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_flags     <= '0;
            r_mul_fwen  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;
            if (w_mul_start) begin
                r_mul_fwen <= flag_wen;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_res;
                if (flag_wen && w_flag_upd) r_flags <= w_alu_flags;
            end else if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_mul_res;
                if (r_mul_fwen) r_flags <= {(w_mul_res == '0), w_mul_res[MSB], 2'b00};
            end
        end
    end

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk    (clk),
        .resetn (resetn),
        .start  (w_mul_start),
        .a      (w_a),
        .b      (w_b),
        .done   (w_mul_done),
        .result (w_mul_res)
    );

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == MUL);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign flags     = r_flags;

endmodule

// File: doc/ex_unit_mc.md
EX_UNIT_MC -- requirements
Module: ex_unit_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width (power of two, 8..64).
REQ-002 SHALL have derived localparam SH_W = $clog2(DATA_W), meaning shift-amount width.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  unit can accept an operation this cycle.
REQ-008 op  input  4  operation code per REQ-014.
REQ-009 src_a, src_b  input  DATA_W each  register operands.
REQ-010 immed  input  DATA_W  immediate; immed_sel input 1 selects immed in place of src_a.
REQ-011 shamt_imm  input  SH_W  immediate shift amount.
REQ-012 flag_wen  input  1  update flags on completion of this operation.
REQ-013 out_valid output 1 one-cycle result strobe; data_out output DATA_W result; flags output 4 {Z,N,C,V} as [3..0]; busy output 1 multiply in progress.

Function
REQ-014 op encoding SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR, 7 ASR, 8 MUL; 9-15 reserved.
REQ-015 Operand A SHALL be immed when immed_sel=1, else src_a; operand B SHALL be src_b.
REQ-016 Shifts SHALL shift B by shamt = immed_sel ? shamt_imm : src_a[SH_W-1:0].
REQ-017 An op SHALL be accepted on a rising edge where in_valid & in_ready; all inputs, including flag_wen, are captured at that edge.
REQ-018 in_ready SHALL equal (state==IDLE); busy SHALL equal (state==MUL).
REQ-019 For non-MUL ops accepted at edge k, data_out SHALL be registered at edge k and out_valid SHALL be high for exactly the following cycle; this allows back-to-back throughput of 1 op/cycle.
REQ-020 MUL SHALL enter state MUL with a DATA_W-iteration counter, doing one shift-add iteration per edge; after the last iteration (edge k+DATA_W) it returns to IDLE, loads data_out, and pulses out_valid for one cycle.
REQ-021 MUL result SHALL be the low DATA_W bits of the unsigned product.
REQ-022 in_valid during MUL SHALL be ignored; there is no abort except reset.
REQ-023 Z SHALL be set when result==0; N SHALL be result[DATA_W-1].
REQ-024 ADD/SUB C SHALL be the carry out, with SUB C=1 meaning no borrow (A>=B unsigned); V SHALL be the two's-complement overflow.
REQ-025 AND/OR/XOR SHALL leave C and V unchanged.
REQ-026 Shift C SHALL be the last bit shifted out; for shamt=0 the result SHALL equal B, with C and V unchanged.
REQ-027 MUL SHALL clear C and V.
REQ-028 Flags SHALL update only on the edge that raises out_valid, and only when the captured flag_wen=1.
REQ-029 Reserved ops SHALL complete as non-MUL with data_out=0, pulse out_valid, and never write flags.
REQ-030 data_out SHALL hold its last value until the next completion.

Reset
REQ-031 While resetn=0: state=IDLE, in_ready=1 (combinational from state), busy=0, out_valid=0, data_out=0, flags=4'b0000.
REQ-032 Reset asserted mid-MUL SHALL abort the multiply, produce no out_valid, and leave flags at 0.

Structure
REQ-033 Shared package ex_pkg SHALL hold the op enum, flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0) and the state enum {IDLE, MUL}.
REQ-034 The iterative multiplier SHALL be sub-module ex_mul_iter (start, done, DATA_W parameter), with the same clk/resetn.
REQ-035 ALU and shifter SHALL be combinational inside ex_unit_mc.

Verification (DATA_W=32)
REQ-036 ADD 0x7FFFFFFF+1, flag_wen=1 -> next cycle out_valid=1, data_out=0x80000000, flags Z0 N1 C0 V1.
REQ-037 SUB 5-5 then, back-to-back, LSR B=0x3 shamt_imm=1 immed_sel=1 -> out_valid on two consecutive cycles; 0/Z1 C1, then 0x1/C1.
REQ-038 MUL 0xFFFF x 0x10001 -> in_ready low 32 cycles, out_valid in cycle 33 after acceptance, data_out=0xFFFFFFFF, C=V=0, N=1.
REQ-039 MUL with resetn pulsed low at iteration 10 -> no out_valid, flags=0, in_ready=1 after release.
REQ-040 XOR with flag_wen=0 after flags=0xF; then op=12 -> flags stay 0xF; reserved op gives data_out=0 with out_valid pulse.
